// File: rtl/gmux_sel_ctrl.sv
// Round-robin sequencer for the GMUX IS0 select: gates the muxed clock, drains, switches, settles, acks.
// Optional LOCK input (stalls new grants) is compiled in with `define GMUX_SEL_CTRL_LOCK_EN.
module gmux_sel_ctrl #(
   parameter int unsigned DRAIN_CYCLES  = 4,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter logic        RESET_SEL     = 1'b0
) (
   input  logic clk,
   input  logic rstn,
`ifdef GMUX_SEL_CTRL_LOCK_EN
   input  logic lock,
`endif
   input  logic req0_vld,
   input  logic req0_sel,
   output logic req0_ack,
   input  logic req1_vld,
   input  logic req1_sel,
   output logic req1_ack,
   output logic is0,
   output logic gate_en,
   output logic busy,
   output logic last_gnt
);

   typedef enum logic [1:0] {IDLE, DRAIN, SETTLE, ACK} state_t;

   localparam logic [7:0] DRAIN_LOAD  = 8'(DRAIN_CYCLES - 1);
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   state_t     state, next_state;
   logic [7:0] cnt, next_cnt;
   logic       tgt, next_tgt;
   logic       next_is0, next_gate_en, next_busy, next_last_gnt;
   logic       next_req0_ack, next_req1_ack;
   logic       lock_i;
   logic       winner, win_sel;

`ifdef GMUX_SEL_CTRL_LOCK_EN
   assign lock_i = lock;
`else
   assign lock_i = 1'b0;
`endif

   // On a tie the requester that did not win last time is served.
   assign winner  = (req0_vld && req1_vld) ? ~last_gnt : req1_vld;
   assign win_sel = winner ? req1_sel : req0_sel;

   always_comb begin
      next_state    = state;
      next_cnt      = cnt;
      next_tgt      = tgt;
      next_is0      = is0;
      next_gate_en  = gate_en;
      next_last_gnt = last_gnt;
      next_req0_ack = 1'b0;
      next_req1_ack = 1'b0;
      case (state)
         IDLE: begin
            if ((req0_vld || req1_vld) && !lock_i) begin
               next_last_gnt = winner;
               next_tgt      = win_sel;
               if (win_sel == is0) begin
                  next_state    = ACK;
                  next_req0_ack = ~winner;
                  next_req1_ack = winner;
               end else begin
                  next_gate_en = 1'b0;
                  next_cnt     = DRAIN_LOAD;
                  next_state   = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (cnt == 8'd0) begin
               next_is0   = tgt;
               next_cnt   = SETTLE_LOAD;
               next_state = SETTLE;
            end else begin
               next_cnt = cnt - 8'd1;
            end
         end
         SETTLE: begin
            if (cnt == 8'd0) begin
               next_gate_en  = 1'b1;
               next_state    = ACK;
               next_req0_ack = ~last_gnt;
               next_req1_ack = last_gnt;
            end else begin
               next_cnt = cnt - 8'd1;
            end
         end
         ACK: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      next_busy = (next_state != IDLE);
   end

   // Every output is registered from its next-value so nothing downstream sees comb glitches.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         cnt      <= 8'd0;
         tgt      <= RESET_SEL;
         is0      <= RESET_SEL;
         gate_en  <= 1'b1;
         busy     <= 1'b0;
         last_gnt <= 1'b1;
         req0_ack <= 1'b0;
         req1_ack <= 1'b0;
      end else begin
         state    <= next_state;
         cnt      <= next_cnt;
         tgt      <= next_tgt;
         is0      <= next_is0;
         gate_en  <= next_gate_en;
         busy     <= next_busy;
         last_gnt <= next_last_gnt;
         req0_ack <= next_req0_ack;
         req1_ack <= next_req1_ack;
      end
   end

endmodule

// File: tb/tb_gmux_sel_ctrl.sv
// Directed self-checking bench for gmux_sel_ctrl (DRAIN=4, SETTLE=8, RESET_SEL=0).
// LOCK scenario is included only when GMUX_SEL_CTRL_LOCK_EN is defined.
module tb_gmux_sel_ctrl;

   logic clk = 1'b0;
   logic rstn;
   logic req0_vld, req0_sel, req1_vld, req1_sel;
   logic req0_ack, req1_ack, is0, gate_en, busy, last_gnt;
`ifdef GMUX_SEL_CTRL_LOCK_EN
   logic lock;
`endif

   int checks   = 0;
   int failures = 0;

   gmux_sel_ctrl #(
      .DRAIN_CYCLES(4),
      .SETTLE_CYCLES(8),
      .RESET_SEL(1'b0)
   ) dut (
      .clk(clk),
      .rstn(rstn),
`ifdef GMUX_SEL_CTRL_LOCK_EN
      .lock(lock),
`endif
      .req0_vld(req0_vld),
      .req0_sel(req0_sel),
      .req0_ack(req0_ack),
      .req1_vld(req1_vld),
      .req1_sel(req1_sel),
      .req1_ack(req1_ack),
      .is0(is0),
      .gate_en(gate_en),
      .busy(busy),
      .last_gnt(last_gnt)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v0, input logic s0, input logic v1, input logic s1);
      req0_vld = v0;
      req0_sel = s0;
      req1_vld = v1;
      req1_sel = s1;
   endtask

   // Grant edge is the first step; checks cycles T0+1..T0+13 of a switching sequence.
   task automatic switchSequence(input string tag, input logic who, input logic oldSel, input logic newSel);
      for (int k = 1; k <= 13; k++) begin
         step(1);
         checkOutput({tag, "_gate"}, gate_en, (k <= 12) ? 1'b0 : 1'b1);
         checkOutput({tag, "_is0"}, is0, (k >= 5) ? newSel : oldSel);
         checkOutput({tag, "_ack0"}, req0_ack, (k == 13 && who == 1'b0));
         checkOutput({tag, "_ack1"}, req1_ack, (k == 13 && who == 1'b1));
         checkOutput({tag, "_busy"}, busy, 1'b1);
         if (k == 1) checkOutput({tag, "_lastgnt"}, last_gnt, who);
      end
      if (who) req1_vld = 1'b0;
      else req0_vld = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_is0"}, is0, 1'b0);
      checkOutput({tag, "_gate"}, gate_en, 1'b1);
      checkOutput({tag, "_busy"}, busy, 1'b0);
      checkOutput({tag, "_ack0"}, req0_ack, 1'b0);
      checkOutput({tag, "_ack1"}, req1_ack, 1'b0);
      checkOutput({tag, "_lastgnt"}, last_gnt, 1'b1);
   endtask

   initial begin
      rstn = 1'b0;
`ifdef GMUX_SEL_CTRL_LOCK_EN
      lock = 1'b0;
`endif
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      step(3);
      checkResetValues("reset");
      rstn = 1'b1;
      step(2);

      // No-switch grant: acked in T0+1 only, gate never drops.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      step(1);
      checkOutput("noswitch_ack0", req0_ack, 1'b1);
      checkOutput("noswitch_ack1", req1_ack, 1'b0);
      checkOutput("noswitch_busy", busy, 1'b1);
      checkOutput("noswitch_gate", gate_en, 1'b1);
      checkOutput("noswitch_is0", is0, 1'b0);
      checkOutput("noswitch_lastgnt", last_gnt, 1'b0);
      req0_vld = 1'b0;
      step(1);
      checkOutput("noswitch_ack0_end", req0_ack, 1'b0);
      checkOutput("noswitch_busy_end", busy, 1'b0);
      checkOutput("noswitch_gate_end", gate_en, 1'b1);

      // Switch 0 -> 1 by requester 1.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      switchSequence("switch", 1'b1, 1'b0, 1'b1);
      step(1);
      checkOutput("switch_busy_end", busy, 1'b0);
      checkOutput("switch_ack1_end", req1_ack, 1'b0);
      checkOutput("switch_is0_end", is0, 1'b1);

      // Reset from IS0 = 1 snaps the select back and restores last_gnt.
      rstn = 1'b0;
      #1;
      checkResetValues("reset2");
      step(1);
      rstn = 1'b1;
      step(1);

      // Tie after reset: requester 0 first, then requester 1 switches back.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      switchSequence("tie_r0", 1'b0, 1'b0, 1'b1);
      step(1);
      checkOutput("tie_idle_busy", busy, 1'b0);
      checkOutput("tie_idle_lastgnt", last_gnt, 1'b0);
      switchSequence("tie_r1", 1'b1, 1'b1, 1'b0);
      step(1);
      checkOutput("tie_end_busy", busy, 1'b0);

      // Back-to-back no-switch tie: second grant two cycles after the first.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      step(1);
      checkOutput("b2b_ack0", req0_ack, 1'b1);
      checkOutput("b2b_ack1_early", req1_ack, 1'b0);
      checkOutput("b2b_lastgnt0", last_gnt, 1'b0);
      req0_vld = 1'b0;
      step(1);
      checkOutput("b2b_gap_ack0", req0_ack, 1'b0);
      checkOutput("b2b_gap_ack1", req1_ack, 1'b0);
      checkOutput("b2b_gap_busy", busy, 1'b0);
      step(1);
      checkOutput("b2b_ack1", req1_ack, 1'b1);
      checkOutput("b2b_lastgnt1", last_gnt, 1'b1);
      checkOutput("b2b_gate", gate_en, 1'b1);
      req1_vld = 1'b0;
      step(1);

      // Reset in DRAIN (T0+3): gate released immediately, no ACK afterward.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      step(3);
      checkOutput("middrain_gate_before", gate_en, 1'b0);
      rstn = 1'b0;
      #1;
      checkResetValues("middrain");
      req0_vld = 1'b0;
      step(2);
      rstn = 1'b1;
      for (int k = 0; k < 15; k++) begin
         step(1);
         checkOutput("middrain_noack0", req0_ack, 1'b0);
         checkOutput("middrain_gate_after", gate_en, 1'b1);
      end

      // Reset in SETTLE after IS0 has already moved to 1.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      step(8);
      checkOutput("midsettle_is0_before", is0, 1'b1);
      checkOutput("midsettle_gate_before", gate_en, 1'b0);
      rstn = 1'b0;
      #1;
      checkResetValues("midsettle");
      req1_vld = 1'b0;
      step(2);
      rstn = 1'b1;
      step(2);
      checkOutput("midsettle_noack1", req1_ack, 1'b0);

`ifdef GMUX_SEL_CTRL_LOCK_EN
      // Locked: requester 0 waits, no grant for 20 cycles; grant on the edge lock is seen low.
      lock = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         step(1);
         checkOutput("lock_busy", busy, 1'b0);
         checkOutput("lock_ack0", req0_ack, 1'b0);
      end
      lock = 1'b0;
      step(1);
      checkOutput("unlock_ack0", req0_ack, 1'b1);
      checkOutput("unlock_busy", busy, 1'b1);
      req0_vld = 1'b0;
      step(1);
      checkOutput("unlock_busy_end", busy, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
